renas_write_buffer: RTL

- Posted-store buffer between the L1 D-cache write path and the dual-port main memory data port.
- Accepts word writes from the cache and queues them in a FIFO.
- Drains entries one at a time to the memory side over a req/ack handshake.
- Provides a combinational load-lookup so the cache can read data that is still pending in the buffer.

---
 rtl/renas_write_buffer_pkg.sv | 18 +
 rtl/renas_write_buffer_match.sv | 34 +++
 rtl/renas_write_buffer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/renas_write_buffer_pkg.sv
// Shared types and default sizing for the renas posted-store write buffer.
package renas_wb_package;
   localparam int unsigned WB_DEPTH = 4;
   localparam int unsigned ADDR_W   = 30;
   localparam int unsigned DATA_W   = 32;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RETIRE = 2'd2
   } wb_state_e;
endpackage

// File: rtl/renas_write_buffer_match.sv
// Address matcher: per-entry hit vector plus index of the youngest hit (closest to wr_ptr-1).
module renas_wb_match #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 30
) (
   input  logic [DEPTH-1:0]             valid,
   input  logic [DEPTH-1:0][ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0]            key,
   input  logic [$clog2(DEPTH)-1:0]     wr_ptr,
   output logic [DEPTH-1:0]             match_vec,
   output logic [$clog2(DEPTH)-1:0]     sel
);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   always_comb begin
      match_vec = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         match_vec[i] = valid[i] && (addr[i] == key);
      end
   end

   // Walk from oldest to youngest slot so the youngest hit is assigned last.
   always_comb begin
      logic [PTR_W-1:0] idx;
      sel = '0;
      idx = '0;
      for (int k = int'(DEPTH); k >= 1; k--) begin
         idx = wr_ptr - PTR_W'(k);
         if (match_vec[idx]) begin
            sel = idx;
         end
      end
   end
endmodule

// File: rtl/renas_write_buffer.sv
// Posted-store write buffer: queues D-cache stores and drains them to memory over req/ack.
// Optional macro WB_COALESCE_EN merges a store into a queued entry that is not being drained.
module renas_write_buffer #(
   parameter int unsigned WB_DEPTH = renas_wb_package::WB_DEPTH,
   parameter int unsigned ADDR_W   = renas_wb_package::ADDR_W,
   parameter int unsigned DATA_W   = renas_wb_package::DATA_W
) (
   input  logic              clk_l2,
   input  logic              rst,
   input  logic              wb_req,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ack,
   output logic              full_flag,
   output logic              empty_flag,
   input  logic [ADDR_W-1:0] lkp_addr,
   output logic              lkp_hit,
   output logic [DATA_W-1:0] lkp_data,
   output logic              mem_req,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack
);
   import renas_wb_package::*;

   localparam int unsigned PTR_W = $clog2(WB_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [1:0] ST_IDLE   = 2'(IDLE);
   localparam logic [1:0] ST_ISSUE  = 2'(ISSUE);
   localparam logic [1:0] ST_RETIRE = 2'(RETIRE);

   logic [1:0]                       state_q, state_d;
   logic [PTR_W-1:0]                 wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]                 count_q;
   logic [WB_DEPTH-1:0]              valid_q;
   logic [WB_DEPTH-1:0][ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]                data_q [WB_DEPTH];

   logic                             mem_req_d;
   logic [31:0]                      mem_addr_d;
   logic [DATA_W-1:0]                mem_wdata_d;

   logic                             push_c, pop_c, coal_c;
   logic [PTR_W-1:0]                 coal_sel;
   logic [WB_DEPTH-1:0]              lkp_vec;
   logic [PTR_W-1:0]                 lkp_sel;

   assign full_flag  = (count_q == CNT_W'(WB_DEPTH));
   assign empty_flag = (count_q == '0);

   renas_wb_match #(.DEPTH(WB_DEPTH), .ADDR_W(ADDR_W)) u_lkp_match (
      .valid     (valid_q),
      .addr      (addr_q),
      .key       (lkp_addr),
      .wr_ptr    (wr_ptr_q),
      .match_vec (lkp_vec),
      .sel       (lkp_sel)
   );

   assign lkp_hit  = |lkp_vec;
   assign lkp_data = lkp_hit ? data_q[lkp_sel] : '0;

`ifdef WB_COALESCE_EN
   logic [WB_DEPTH-1:0] coal_valid;
   logic [WB_DEPTH-1:0] coal_vec;

   // The head is being captured (IDLE) or is in flight (ISSUE) outside RETIRE, so never merge into it.
   always_comb begin
      coal_valid = valid_q;
      if (state_q != ST_RETIRE) begin
         coal_valid[rd_ptr_q] = 1'b0;
      end
   end

   renas_wb_match #(.DEPTH(WB_DEPTH), .ADDR_W(ADDR_W)) u_coal_match (
      .valid     (coal_valid),
      .addr      (addr_q),
      .key       (wb_addr),
      .wr_ptr    (wr_ptr_q),
      .match_vec (coal_vec),
      .sel       (coal_sel)
   );

   assign coal_c = wb_req && (|coal_vec);
`else
   assign coal_c   = 1'b0;
   assign coal_sel = '0;
`endif

   assign push_c = wb_req && !full_flag && !coal_c;
   assign pop_c  = (state_q == ST_ISSUE) && mem_ack;

   // Drain FSM next-state and registered memory-side outputs.
   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      case (state_q)
         ST_IDLE: begin
            if (!empty_flag) begin
               mem_req_d   = 1'b1;
               mem_addr_d  = 32'({addr_q[rd_ptr_q], 2'b00});
               mem_wdata_d = data_q[rd_ptr_q];
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (mem_ack) begin
               mem_req_d = 1'b0;
               state_d   = ST_RETIRE;
            end
         end
         ST_RETIRE: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_l2) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         valid_q   <= '0;
         wb_ack    <= 1'b0;
         mem_req   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         state_q   <= state_d;
         mem_req   <= mem_req_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         wb_ack    <= push_c | coal_c;
         count_q   <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
         if (push_c) begin
            valid_q[wr_ptr_q] <= 1'b1;
            wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            valid_q[rd_ptr_q] <= 1'b0;
            rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // Payload storage; qualified by valid_q so it needs no reset.
   always_ff @(posedge clk_l2) begin
      if (push_c) begin
         addr_q[wr_ptr_q] <= wb_addr;
         data_q[wr_ptr_q] <= wb_data;
      end
      if (coal_c) begin
         data_q[coal_sel] <= wb_data;
      end
   end
endmodule
